// File: rtl/laser_pool.sv
// rtl/laser_pool.sv - pool of NUM_SHOTS laser slots: spawn on fire, per-frame motion, hits, pixel mask
// Everything runs in the pixel-clock domain; the frame tick is the vsync rising edge.
module laser_pool #(
    parameter int NUM_SHOTS = 4,
    parameter int CANNON_Y  = 440,
    parameter int X_OFFSET  = 14,
    parameter int SPEED     = 4,
    parameter int LASER_W   = 2,
    parameter int LASER_H   = 8,
    parameter int COOLDOWN  = 8
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [9:0]           hpos_i,
    input  logic [9:0]           vpos_i,
    input  logic                 vsync_i,
    input  logic                 shoot_i,
    input  logic [9:0]           cannon_x_i,
    input  logic                 hit_valid_i,
    input  logic [2:0]           hit_idx_i,
    output logic                 laser_gfx_o,
    output logic [2:0]           gfx_idx_o,
    output logic [NUM_SHOTS-1:0] active_mask_o,
    output logic [7:0]           shots_fired_o
);

    localparam int CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

    logic [NUM_SHOTS-1:0] active_q, active_d;
    logic [9:0]           x_q [NUM_SHOTS];
    logic [9:0]           x_d [NUM_SHOTS];
    logic [9:0]           y_q [NUM_SHOTS];
    logic [9:0]           y_d [NUM_SHOTS];
    logic [CW-1:0]        cooldown_q, cooldown_d;
    logic                 shoot_prev_q, shoot_prev_d;
    logic                 vsync_q;
    logic [7:0]           fired_q, fired_d;
    logic                 gfx_q, gfx_d;
    logic [2:0]           gidx_q, gidx_d;

    logic tick, press_ok, spawned;
    logic match;

    assign tick = vsync_i & ~vsync_q;

    always_comb begin
        active_d     = active_q;
        x_d          = x_q;
        y_d          = y_q;
        cooldown_d   = cooldown_q;
        shoot_prev_d = shoot_prev_q;
        fired_d      = fired_q;
        press_ok     = 1'b0;
        spawned      = 1'b0;

        // Hits land first so a slot hit on the tick is neither moved nor blocks a spawn.
        for (int i = 0; i < NUM_SHOTS; i++) begin
            if (hit_valid_i && hit_idx_i == 3'(i)) begin
                active_d[i] = 1'b0;
            end
        end

        if (tick) begin
            for (int i = 0; i < NUM_SHOTS; i++) begin
                if (active_d[i]) begin
                    if (y_q[i] < 10'(SPEED)) begin
                        active_d[i] = 1'b0;
                    end else begin
                        y_d[i] = y_q[i] - 10'(SPEED);
                    end
                end
            end

            shoot_prev_d = shoot_i;
            press_ok     = shoot_i & ~shoot_prev_q & (cooldown_q == '0);

            for (int i = 0; i < NUM_SHOTS; i++) begin
                if (press_ok && !spawned && !active_d[i]) begin
                    active_d[i] = 1'b1;
                    x_d[i]      = cannon_x_i + 10'(X_OFFSET);
                    y_d[i]      = 10'(CANNON_Y - LASER_H);
                    spawned     = 1'b1;
                end
            end

            if (spawned) begin
                cooldown_d = CW'(COOLDOWN);
                fired_d    = fired_q + 8'd1;
            end else if (cooldown_q != '0) begin
                cooldown_d = cooldown_q - CW'(1);
            end
        end
    end

    // Walk from the highest slot down so the lowest matching index wins.
    always_comb begin
        gfx_d  = 1'b0;
        gidx_d = 3'd0;
        match  = 1'b0;
        for (int i = NUM_SHOTS - 1; i >= 0; i--) begin
            match = active_q[i]
                  && ({1'b0, hpos_i} >= {1'b0, x_q[i]})
                  && ({1'b0, hpos_i} <  {1'b0, x_q[i]} + 11'(LASER_W))
                  && ({1'b0, vpos_i} >= {1'b0, y_q[i]})
                  && ({1'b0, vpos_i} <  {1'b0, y_q[i]} + 11'(LASER_H));
            if (match) begin
                gfx_d  = 1'b1;
                gidx_d = 3'(i);
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            active_q     <= '0;
            cooldown_q   <= '0;
            shoot_prev_q <= 1'b0;
            vsync_q      <= 1'b0;
            fired_q      <= 8'd0;
            gfx_q        <= 1'b0;
            gidx_q       <= 3'd0;
            for (int i = 0; i < NUM_SHOTS; i++) begin
                x_q[i] <= 10'd0;
                y_q[i] <= 10'd0;
            end
        end else begin
            active_q     <= active_d;
            cooldown_q   <= cooldown_d;
            shoot_prev_q <= shoot_prev_d;
            vsync_q      <= vsync_i;
            fired_q      <= fired_d;
            gfx_q        <= gfx_d;
            gidx_q       <= gidx_d;
            for (int i = 0; i < NUM_SHOTS; i++) begin
                x_q[i] <= x_d[i];
                y_q[i] <= y_d[i];
            end
        end
    end

    assign laser_gfx_o   = gfx_q;
    assign gfx_idx_o     = gidx_q;
    assign active_mask_o = active_q;
    assign shots_fired_o = fired_q;

endmodule
